apb_master: RTL and testbench

APB3 requester that turns a single-entry command/response stream into PSEL/PENABLE/PWRITE/PADDR/PWDATA bus cycles. It sits on the bridge's downstream side, facing one APB completer (or a decoder feeding several). It supports unlimited completer wait states with a programmable timeout, back-to-back transfers and error reporting on timeout.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_wait_timer.sv | 40 ++++
 rtl/apb_master.sv | 116 +++++++++++
 tb/tb_apb_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester and the team's APB completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int APB_ADDR_W          = 32;
   localparam int APB_DEFAULT_TIMEOUT = 16;

   // Width of a counter that must hold 0..t; at least one bit when t is 0.
   function automatic int timer_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_o flags the last permitted wait cycle.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = APB_DEFAULT_TIMEOUT
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int            CW   = timer_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] MAXV = {CW{1'b1}};

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturating increment keeps the counter sane when the timeout is disabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAXV)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one command in flight, wait states with timeout abort,
// back-to-back transfers by going ACCESS->SETUP on a same-edge accept.
module apb_master
   import apb_pkg::*;
#(
   parameter int pdataWidth = 32,
   parameter int TIMEOUT    = APB_DEFAULT_TIMEOUT
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [APB_ADDR_W-1:0] cmd_addr,
   input  logic [pdataWidth-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [pdataWidth-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [APB_ADDR_W-1:0] PADDR,
   output logic [pdataWidth-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [pdataWidth-1:0] PRDATA,
   output apb_state_t            dbg_state_o
);

   // Handshake: a command transfers on any rising PCLK edge where
   // cmd_valid && cmd_ready; rsp_valid is a single-cycle pulse with no backpressure.

   apb_state_t state_q, state_d;

   logic                  pwrite_q;
   logic [APB_ADDR_W-1:0] paddr_q;
   logic [pdataWidth-1:0] pwdata_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [pdataWidth-1:0] rsp_rdata_q;

   logic accept, complete, abort, expired, wait_inc;

   assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
   assign accept    = cmd_valid && cmd_ready;
   assign complete  = (state_q == ACCESS) && PREADY;
   assign wait_inc  = (state_q == ACCESS) && !PREADY;
   assign abort     = wait_inc && expired;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .clr_i     (accept),
      .inc_i     (wait_inc),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               state_d = accept ? SETUP : IDLE;
            end else if (abort) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bus fields are only loaded on accept, so they stay put through wait states.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr & ~APB_ADDR_W'(3);
            pwdata_q <= cmd_wdata;
         end
         rsp_valid_q <= complete || abort;
         rsp_err_q   <= abort;
         if (complete && !pwrite_q) begin
            rsp_rdata_q <= PRDATA;
         end
      end
   end

   assign PSEL        = (state_q != IDLE);
   assign PENABLE     = (state_q == ACCESS);
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small in-bench APB completer model.
module tb_apb_master;
   import apb_pkg::*;

   logic        PCLK;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;
   apb_state_t  dbg_state;

   int checks   = 0;
   int failures = 0;

   apb_master #(
      .pdataWidth (32),
      .TIMEOUT    (4)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // completer model: PREADY rises after waits_cfg wait cycles of ACCESS
   int          waits_cfg = 0;
   int          acc_cnt;
   logic [31:0] mem [0:63];

   always_ff @(posedge PCLK) begin
      if (!PENABLE) acc_cnt <= 0;
      else if (!PREADY) acc_cnt <= acc_cnt + 1;
      if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[7:2]] <= PWDATA;
   end

   assign PREADY = PENABLE && (acc_cnt >= waits_cfg);
   assign PRDATA = mem[PADDR[7:2]];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // driver: one standalone transfer, returns latency (cycles after accept edge)
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, output int lat, output logic err,
                          output logic [31:0] rd, output logic shape_ok);
      int   k;
      logic done;
      shape_ok = 1'b1;
      lat      = -1;
      err      = 1'b0;
      rd       = '0;
      done     = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      waits_cfg = waits;
      k = 0;
      while (!cmd_ready && k < 20) begin
         @(negedge PCLK);
         k++;
      end
      if (!cmd_ready) chk("accept_wait", 64'(cmd_ready), 64'd1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = 32'hFFFF_FFFF;
      cmd_wdata = ~wd;
      k = 1;
      while (!done && k <= 40) begin
         if (rsp_valid) begin
            lat  = k;
            err  = rsp_err;
            rd   = rsp_rdata;
            done = 1'b1;
            if (PSEL) shape_ok = 1'b0;
         end else begin
            if (k == 1 && !(PSEL && !PENABLE)) shape_ok = 1'b0;
            if (k >= 2 && !(PSEL && PENABLE)) shape_ok = 1'b0;
            if (PSEL && ((PADDR !== (addr & ~32'h3)) || (PWRITE !== wr) ||
                         (wr && (PWDATA !== wd)))) shape_ok = 1'b0;
         end
         @(negedge PCLK);
         k++;
      end
      if (done && rsp_valid) shape_ok = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int          lat;
      logic        err;
      logic [31:0] rd;
      logic        shape_ok;
      logic [19:0] psel_v, pen_v, rsp_v;
      logic        addr_ok, acc, rsp_seen;
      int          idx;

      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF,   0, 3, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h10, 32'h0,          0, 3, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h20, 32'h12345678,   0, 3, 1'b0, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 32'h20, 32'h0,          3, 6, 1'b0, 32'h12345678};
      vecs[4] = '{1'b1, 32'h13, 32'hA5A5A5A5,   0, 3, 1'b0, 32'h12345678};
      vecs[5] = '{1'b0, 32'h10, 32'h0,          0, 3, 1'b0, 32'hA5A5A5A5};
      vecs[6] = '{1'b0, 32'h20, 32'h0,        255, 6, 1'b1, 32'hA5A5A5A5};
      vecs[7] = '{1'b0, 32'h20, 32'h0,          3, 6, 1'b0, 32'h12345678};
      vecs[8] = '{1'b1, 32'h24, 32'h0F0F0F0F,   2, 5, 1'b0, 32'h12345678};
      vecs[9] = '{1'b0, 32'h24, 32'h0,          1, 4, 1'b0, 32'h0F0F0F0F};

      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PRESETn   = 1'b0;
      #1;
      chk("rst_psel",    64'(PSEL), 64'd0);
      chk("rst_penable", 64'(PENABLE), 64'd0);
      chk("rst_paddr",   64'(PADDR), 64'd0);
      chk("rst_rsp",     64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
      chk("rst_state",   64'(dbg_state), 64'(IDLE));
      repeat (3) @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, lat, err, rd, shape_ok);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
         chk($sformatf("v%0d_bus_shape", i), 64'(shape_ok), 64'd1);
      end

      // back-to-back: four writes with cmd_valid held high
      @(negedge PCLK);
      waits_cfg = 0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h100;
      idx       = 0;
      addr_ok   = 1'b1;
      for (int c = 0; c < 20; c++) begin
         psel_v[c] = PSEL;
         pen_v[c]  = PENABLE;
         rsp_v[c]  = rsp_valid;
         if (PSEL && PENABLE && (PADDR !== 32'((c / 2 - 1) * 4))) addr_ok = 1'b0;
         acc = cmd_valid && cmd_ready;
         @(negedge PCLK);
         if (acc) begin
            idx++;
            if (idx < 4) begin
               cmd_addr  = 32'(idx * 4);
               cmd_wdata = 32'(32'h100 + idx);
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      chk("b2b_psel",    64'(psel_v), 64'h001FE);
      chk("b2b_penable", 64'(pen_v),  64'h00154);
      chk("b2b_rsp",     64'(rsp_v),  64'h002A8);
      chk("b2b_paddr",   64'(addr_ok), 64'd1);
      run_txn(1'b0, 32'h8, 32'h0, 0, lat, err, rd, shape_ok);
      chk("b2b_readback", 64'(rd), 64'h102);

      // reset during ACCESS wait of a write
      @(negedge PCLK);
      waits_cfg = 255;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h30;
      cmd_wdata = 32'hCAFEF00D;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("mid_in_access", 64'({PSEL, PENABLE}), 64'd3);
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_rst_bus",   64'({PSEL, PENABLE, PWRITE}), 64'd0);
      chk("mid_rst_paddr", 64'(PADDR), 64'd0);
      chk("mid_rst_pwdata", 64'(PWDATA), 64'd0);
      chk("mid_rst_rsp",   64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
      rsp_seen = 1'b0;
      repeat (3) begin
         @(negedge PCLK);
         rsp_seen = rsp_seen | rsp_valid;
      end
      PRESETn = 1'b1;
      repeat (6) begin
         @(negedge PCLK);
         rsp_seen = rsp_seen | rsp_valid;
      end
      chk("mid_no_rsp", 64'(rsp_seen), 64'd0);
      run_txn(1'b1, 32'h30, 32'h0BADCAFE, 0, lat, err, rd, shape_ok);
      chk("post_rst_lat",   64'(lat), 64'd3);
      chk("post_rst_shape", 64'({shape_ok, err}), 64'h2);
      run_txn(1'b0, 32'h30, 32'h0, 0, lat, err, rd, shape_ok);
      chk("post_rst_read",  64'(rd), 64'h0BADCAFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
